// File: rtl/nn_pkg.sv
// Shared types and default sizes for the neural-layer sequencer blocks.
package nn_pkg;

   localparam int DEFAULT_DATA_WIDTH = 8;
   localparam int DEFAULT_NUM_INPUTS = 16;

   typedef enum logic [2:0] {
      LOAD   = 3'd0,
      READY  = 3'd1,
      STREAM = 3'd2,
      WAIT   = 3'd3,
      DONE   = 3'd4
   } seq_state_t;

endpackage

// File: rtl/layer_input_buffer.sv
// Input vector storage with a write counter (load side) and a read index (stream side).
// Both counters saturate at the last entry; the sequencer uses the *_last flags as terminal strobes.
module layer_input_buffer
   import nn_pkg::*;
#(
   parameter int numInputs    = DEFAULT_NUM_INPUTS,
   parameter int dataWidth    = DEFAULT_DATA_WIDTH,
   parameter int counterWidth = $clog2(numInputs)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    wr_en,
   input  logic [dataWidth-1:0]    wr_data,
   input  logic                    wr_clr,
   input  logic                    rd_clr,
   input  logic                    rd_inc,
   output logic                    wr_last,
   output logic [counterWidth-1:0] rd_idx,
   output logic                    rd_last,
   output logic [dataWidth-1:0]    rd_data
);

   localparam logic [counterWidth-1:0] LAST_IDX = counterWidth'(numInputs - 1);

   logic [dataWidth-1:0]    mem [numInputs];
   logic [counterWidth-1:0] wr_count;

   // Storage is deliberately left without reset; contents survive aborts and completions.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_count] <= wr_data;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_count <= '0;
         rd_idx   <= '0;
      end else begin
         if (wr_clr)                  wr_count <= '0;
         else if (wr_en && !wr_last)  wr_count <= wr_count + 1'b1;

         if (rd_clr)                  rd_idx <= '0;
         else if (rd_inc && !rd_last) rd_idx <= rd_idx + 1'b1;
      end
   end

   assign wr_last = (wr_count == LAST_IDX);
   assign rd_last = (rd_idx == LAST_IDX);
   assign rd_data = mem[rd_idx];

endmodule

// File: rtl/layer_sequencer.sv
// Buffers one input vector, broadcasts it to a neuron layer and waits for every neuron result.
// Optional macro PRETRAINED_EN removes the runtime weight/bias configuration path.
module layer_sequencer
   import nn_pkg::*;
#(
   parameter int numInputs    = DEFAULT_NUM_INPUTS,
   parameter int numNeurons   = 4,
   parameter int dataWidth    = DEFAULT_DATA_WIDTH,
   parameter int layerNumber  = 0,
   parameter int counterWidth = $clog2(numInputs)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [dataWidth-1:0]    inData,
   input  logic                    inValid,
   output logic                    inReady,
   input  logic                    start,
   output logic [dataWidth-1:0]    neuronIn,
   output logic                    neuronValid,
   output logic [counterWidth-1:0] inputIndex,
   input  logic [numNeurons-1:0]   neuronOutValid,
   output logic                    busy,
   output logic                    done,
   input  logic                    cfgReq,
   input  logic                    cfgIsBias,
   input  logic [31:0]             cfgNeuron,
   input  logic [31:0]             cfgData,
   output logic                    cfgAck,
   output logic                    weightWriteEn,
   output logic                    biasWriteEn,
   output logic [31:0]             weightData,
   output logic [31:0]             biasData,
   output logic [31:0]             config_layer_number,
   output logic [31:0]             config_neuron_number,
   output logic [2:0]              state_dbg
);

   // Input side: inValid & inReady is a transfer; inReady is high only while loading, so
   // data offered at any other time is dropped, and the producer must not assume it was taken.

   seq_state_t state, state_next;

   logic                    wr_en, wr_clr, rd_clr, rd_inc;
   logic                    wr_last, rd_last;
   logic [counterWidth-1:0] rd_idx;
   logic [dataWidth-1:0]    rd_data;
   logic [numNeurons-1:0]   mask, mask_merged;

   layer_input_buffer #(
      .numInputs   (numInputs),
      .dataWidth   (dataWidth),
      .counterWidth(counterWidth)
   ) u_buffer (
      .clk    (clk),
      .reset  (reset),
      .wr_en  (wr_en),
      .wr_data(inData),
      .wr_clr (wr_clr),
      .rd_clr (rd_clr),
      .rd_inc (rd_inc),
      .wr_last(wr_last),
      .rd_idx (rd_idx),
      .rd_last(rd_last),
      .rd_data(rd_data)
   );

   assign mask_merged = mask | neuronOutValid;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= LOAD;
         mask  <= '0;
      end else begin
         state <= state_next;
         if (state == READY && start)            mask <= '0;
         else if (state == STREAM || state == WAIT) mask <= mask_merged;
      end
   end

   // WAIT looks at the merged mask so completion is seen in the same cycle the last strobe lands.
   always_comb begin
      state_next = state;
      wr_en      = 1'b0;
      wr_clr     = 1'b0;
      rd_clr     = 1'b0;
      rd_inc     = 1'b0;
      case (state)
         LOAD: begin
            wr_en = inValid;
            if (inValid && wr_last) state_next = READY;
         end
         READY: begin
            if (start) begin
               rd_clr     = 1'b1;
               state_next = STREAM;
            end
         end
         STREAM: begin
            rd_inc = 1'b1;
            if (rd_last) state_next = WAIT;
         end
         WAIT: begin
            if (&mask_merged) state_next = DONE;
         end
         DONE: begin
            wr_clr     = 1'b1;
            state_next = LOAD;
         end
         default: state_next = LOAD;
      endcase
   end

   assign inReady     = (state == LOAD);
   assign neuronValid = (state == STREAM);
   assign neuronIn    = neuronValid ? rd_data : '0;
   assign inputIndex  = neuronValid ? rd_idx : '0;
   assign busy        = (state == STREAM) || (state == WAIT);
   assign done        = (state == DONE);
   assign state_dbg   = state;

`ifdef PRETRAINED_EN
   assign cfgAck               = 1'b0;
   assign weightWriteEn        = 1'b0;
   assign biasWriteEn          = 1'b0;
   assign weightData           = '0;
   assign biasData             = '0;
   assign config_layer_number  = '0;
   assign config_neuron_number = '0;
`else
   logic cfg_take;

   // A request still held during its own ack cycle is not taken a second time.
   assign cfg_take = cfgReq && !cfgAck && (state == LOAD || state == READY);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cfgAck               <= 1'b0;
         weightWriteEn        <= 1'b0;
         biasWriteEn          <= 1'b0;
         weightData           <= '0;
         biasData             <= '0;
         config_layer_number  <= '0;
         config_neuron_number <= '0;
      end else begin
         cfgAck        <= cfg_take;
         weightWriteEn <= cfg_take && !cfgIsBias;
         biasWriteEn   <= cfg_take && cfgIsBias;
         if (cfg_take) begin
            config_neuron_number <= cfgNeuron;
            config_layer_number  <= 32'(layerNumber);
            if (cfgIsBias) biasData   <= cfgData;
            else           weightData <= cfgData;
         end
      end
   end
`endif

endmodule

// File: tb/tb_layer_sequencer.sv
// Self-checking bench for layer_sequencer: directed corner sequences, a config vector table
// and randomized load/stream/result traffic against a timing model of the layer protocol.
module tb_layer_sequencer;
   import nn_pkg::*;

   localparam int N        = 16;
   localparam int NN       = 4;
   localparam int DW       = 8;
   localparam int CW       = $clog2(N);
   localparam int PLAN_LEN = 64;
`ifdef PRETRAINED_EN
   localparam bit PRE = 1'b1;
`else
   localparam bit PRE = 1'b0;
`endif

   typedef struct {
      logic        is_bias;
      logic [31:0] neuron;
      logic [31:0] data;
      logic        exp_ack;
      logic        exp_wen;
      logic        exp_ben;
      logic [31:0] exp_data;
      logic [31:0] exp_neuron;
   } cfg_vec_t;

   logic           clk = 1'b0;
   logic           reset;
   logic [DW-1:0]  in_data;
   logic           in_valid;
   logic           in_ready;
   logic           start;
   logic [DW-1:0]  neuron_in;
   logic           neuron_valid;
   logic [CW-1:0]  input_index;
   logic [NN-1:0]  neuron_out_valid;
   logic           busy;
   logic           done;
   logic           cfg_req;
   logic           cfg_is_bias;
   logic [31:0]    cfg_neuron;
   logic [31:0]    cfg_data;
   logic           cfg_ack;
   logic           weight_write_en;
   logic           bias_write_en;
   logic [31:0]    weight_data;
   logic [31:0]    bias_data;
   logic [31:0]    config_layer_number;
   logic [31:0]    config_neuron_number;
   logic [2:0]     state_dbg;

   int checks = 0;
   int errors = 0;

   logic [DW-1:0] load_vals [N];
   logic [DW-1:0] exp_mem [N];
   logic [DW-1:0] exp_q [$];
   logic [NN-1:0] nov_plan [PLAN_LEN];
   cfg_vec_t      cfg_vecs [4];

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: actual no finish, required finish before time limit");
      $fatal(1, "watchdog expired");
   end

   layer_sequencer #(
      .numInputs  (N),
      .numNeurons (NN),
      .dataWidth  (DW),
      .layerNumber(0)
   ) dut (
      .clk                 (clk),
      .reset               (reset),
      .inData              (in_data),
      .inValid             (in_valid),
      .inReady             (in_ready),
      .start               (start),
      .neuronIn            (neuron_in),
      .neuronValid         (neuron_valid),
      .inputIndex          (input_index),
      .neuronOutValid      (neuron_out_valid),
      .busy                (busy),
      .done                (done),
      .cfgReq              (cfg_req),
      .cfgIsBias           (cfg_is_bias),
      .cfgNeuron           (cfg_neuron),
      .cfgData             (cfg_data),
      .cfgAck              (cfg_ack),
      .weightWriteEn       (weight_write_en),
      .biasWriteEn         (bias_write_en),
      .weightData          (weight_data),
      .biasData            (bias_data),
      .config_layer_number (config_layer_number),
      .config_neuron_number(config_neuron_number),
      .state_dbg           (state_dbg)
   );

   // ---------------- scoreboard helpers ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual 0x%0h required 0x%0h at t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ---------------- driver tasks ----------------
   task automatic load_range(input int first, input int last_excl, input int valid_pct);
      int k;
      k = first;
      while (k < last_excl) begin
         check("in_ready_load", in_ready, 1);
         in_valid = ($urandom_range(99) < valid_pct);
         in_data  = in_valid ? load_vals[k] : DW'($urandom);
         tick();
         if (in_valid) begin
            exp_mem[k] = load_vals[k];
            k++;
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic load_vector(input int valid_pct);
      load_range(0, N, valid_pct);
      check("in_ready_after_load", in_ready, 0);
   endtask

   task automatic idle_ready(input int n);
      for (int i = 0; i < n; i++) begin
         check("in_ready_ready", in_ready, 0);
         check("neuron_valid_ready", neuron_valid, 0);
         in_valid = 1'($urandom_range(1));
         in_data  = DW'($urandom);
         tick();
      end
      in_valid = 1'b0;
   endtask

   task automatic clear_plan();
      for (int j = 0; j < PLAN_LEN; j++) nov_plan[j] = '0;
   endtask

   task automatic random_plan();
      for (int j = 0; j < PLAN_LEN; j++)
         nov_plan[j] = ($urandom_range(7) == 0) ? NN'($urandom) : '0;
      for (int b = 0; b < NN; b++) nov_plan[$urandom_range(30, 1)][b] = 1'b1;
   endtask

   // Start in the current (READY) period = offset 0. Beats land at offsets 1..N; results
   // are accumulated from offset 1 on; done appears one period after the later of
   // "all results seen" and "first WAIT period" (offset N+1).
   task automatic run_stream(input bit with_cfg);
      logic [NN-1:0] seen;
      int            c;
      int            done_at;
      seen = '0;
      c    = PLAN_LEN - 2;
      for (int j = PLAN_LEN - 1; j >= 1; j--) begin
         seen = '0;
         for (int m = 1; m <= j; m++) seen |= nov_plan[m];
         if (&seen) c = j;
      end
      done_at = ((c > N + 1) ? c : N + 1) + 1;

      exp_q.delete();
      for (int i = 0; i < N; i++) exp_q.push_back(exp_mem[i]);

      check("in_ready_before_start", in_ready, 0);
      start            = 1'b1;
      neuron_out_valid = nov_plan[0];
      if (with_cfg) begin
         cfg_req     = 1'b1;
         cfg_is_bias = 1'b0;
         cfg_neuron  = 32'd3;
         cfg_data    = 32'hCAFE_0042;
      end
      tick();
      start   = 1'b0;
      cfg_req = 1'b0;

      for (int j = 1; j <= done_at; j++) begin
         if (j <= N) begin
            check("neuron_valid_beat", neuron_valid, 1);
            check("input_index_beat", input_index, j - 1);
            check("neuron_in_beat", neuron_in, exp_q.pop_front());
         end else begin
            check("neuron_valid_idle", neuron_valid, 0);
            check("neuron_in_idle", neuron_in, 0);
         end
         check("busy", busy, (j < done_at));
         check("done", done, (j == done_at));
         check("in_ready_stream", in_ready, 0);
         if (with_cfg && j == 1) begin
            check("cfg_ack_with_start", cfg_ack, !PRE);
            check("weight_write_en_with_start", weight_write_en, !PRE);
            check("weight_data_with_start", weight_data, PRE ? 32'h0 : 32'hCAFE_0042);
            check("config_neuron_with_start", config_neuron_number, PRE ? 32'h0 : 32'd3);
         end else begin
            check("cfg_ack_idle", cfg_ack, 0);
         end
         neuron_out_valid = (j < PLAN_LEN) ? nov_plan[j] : '0;
         tick();
      end
      neuron_out_valid = '0;
      check("done_pulse_end", done, 0);
      check("busy_after_done", busy, 0);
      check("in_ready_after_done", in_ready, 1);
   endtask

   // ---------------- test sequence ----------------
   initial begin
      reset            = 1'b0;
      in_data          = '0;
      in_valid         = 1'b0;
      start            = 1'b0;
      neuron_out_valid = '0;
      cfg_req          = 1'b0;
      cfg_is_bias      = 1'b0;
      cfg_neuron       = '0;
      cfg_data         = '0;

      tick();
      tick();
      check("reset_in_ready", in_ready, 1);
      check("reset_neuron_valid", neuron_valid, 0);
      check("reset_neuron_in", neuron_in, 0);
      check("reset_input_index", input_index, 0);
      check("reset_busy", busy, 0);
      check("reset_done", done, 0);
      check("reset_cfg_ack", cfg_ack, 0);
      check("reset_weight_write_en", weight_write_en, 0);
      check("reset_bias_write_en", bias_write_en, 0);
      check("reset_weight_data", weight_data, 0);
      check("reset_bias_data", bias_data, 0);
      check("reset_config_layer", config_layer_number, 0);
      check("reset_config_neuron", config_neuron_number, 0);
      @(negedge clk);
      reset = 1'b1;
      tick();
      check("post_reset_in_ready", in_ready, 1);

      // Configuration vector table, applied while loading.
      cfg_vecs[0] = '{1'b0, 32'd0, 32'h0000_0011, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0};
      cfg_vecs[1] = '{1'b1, 32'd1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0};
      cfg_vecs[2] = '{1'b0, 32'd3, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0};
      cfg_vecs[3] = '{1'b1, 32'd2, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0};
      for (int v = 0; v < 4; v++) begin
         cfg_vecs[v].exp_ack    = !PRE;
         cfg_vecs[v].exp_wen    = !PRE && !cfg_vecs[v].is_bias;
         cfg_vecs[v].exp_ben    = !PRE && cfg_vecs[v].is_bias;
         cfg_vecs[v].exp_data   = PRE ? 32'h0 : cfg_vecs[v].data;
         cfg_vecs[v].exp_neuron = PRE ? 32'h0 : cfg_vecs[v].neuron;
      end
      for (int v = 0; v < 4; v++) begin
         cfg_req     = 1'b1;
         cfg_is_bias = cfg_vecs[v].is_bias;
         cfg_neuron  = cfg_vecs[v].neuron;
         cfg_data    = cfg_vecs[v].data;
         tick();
         cfg_req = 1'b0;
         check("tbl_cfg_ack", cfg_ack, cfg_vecs[v].exp_ack);
         check("tbl_weight_write_en", weight_write_en, cfg_vecs[v].exp_wen);
         check("tbl_bias_write_en", bias_write_en, cfg_vecs[v].exp_ben);
         check("tbl_config_neuron", config_neuron_number, cfg_vecs[v].exp_neuron);
         check("tbl_config_layer", config_layer_number, 0);
         if (cfg_vecs[v].is_bias) check("tbl_bias_data", bias_data, cfg_vecs[v].exp_data);
         else                     check("tbl_weight_data", weight_data, cfg_vecs[v].exp_data);
         tick();
         check("tbl_cfg_ack_drop", cfg_ack, 0);
         check("tbl_write_en_drop", weight_write_en | bias_write_en, 0);
      end

      // Ascending vector, all results during beat 5.
      for (int i = 0; i < N; i++) load_vals[i] = DW'(i + 1);
      load_vector(100);
      clear_plan();
      nov_plan[6] = '1;
      run_stream(1'b0);

      // Results trickle in one bit at a time during WAIT.
      load_vector(100);
      clear_plan();
      nov_plan[18][0] = 1'b1;
      nov_plan[19][1] = 1'b1;
      nov_plan[21][2] = 1'b1;
      nov_plan[24][3] = 1'b1;
      run_stream(1'b0);

      // start while still loading is ignored; data offered in READY is dropped.
      for (int i = 0; i < N; i++) load_vals[i] = DW'(8'hA0 + i);
      load_range(0, 10, 100);
      start = 1'b1;
      tick();
      start = 1'b0;
      check("start_in_load_neuron_valid", neuron_valid, 0);
      check("start_in_load_in_ready", in_ready, 1);
      check("start_in_load_busy", busy, 0);
      load_range(10, N, 100);
      check("in_ready_after_partial_load", in_ready, 0);
      idle_ready(4);
      random_plan();
      run_stream(1'b0);

      // Bias write in READY, then a request that must stall through a stream.
      for (int i = 0; i < N; i++) load_vals[i] = DW'($urandom);
      load_vector(60);
      cfg_req     = 1'b1;
      cfg_is_bias = 1'b1;
      cfg_neuron  = 32'd2;
      cfg_data    = 32'h1234_5678;
      tick();
      cfg_req = 1'b0;
      check("ready_cfg_ack", cfg_ack, !PRE);
      check("ready_bias_write_en", bias_write_en, !PRE);
      check("ready_weight_write_en", weight_write_en, 0);
      check("ready_bias_data", bias_data, PRE ? 32'h0 : 32'h1234_5678);
      check("ready_config_neuron", config_neuron_number, PRE ? 32'h0 : 32'd2);
      tick();
      check("ready_bias_write_en_drop", bias_write_en, 0);
      check("ready_still_ready", in_ready, 0);

      start = 1'b1;
      tick();
      start       = 1'b0;
      cfg_req     = 1'b1;
      cfg_is_bias = 1'b1;
      cfg_neuron  = 32'd2;
      cfg_data    = 32'h1234_5678;
      for (int j = 1; j <= N + 3; j++) begin
         check("stall_cfg_ack", cfg_ack, 0);
         check("stall_bias_write_en", bias_write_en, 0);
         if (j == N + 2) check("stall_done", done, 1);
         neuron_out_valid = (j == 2) ? '1 : '0;
         tick();
      end
      neuron_out_valid = '0;
      check("stall_cfg_ack_in_load", cfg_ack, !PRE);
      check("stall_bias_write_en_in_load", bias_write_en, !PRE);
      check("stall_bias_data_in_load", bias_data, PRE ? 32'h0 : 32'h1234_5678);
      tick();
      check("stall_no_double_ack", cfg_ack, 0);
      cfg_req = 1'b0;
      tick();

      // Config request coinciding with start.
      for (int i = 0; i < N; i++) load_vals[i] = DW'($urandom);
      load_vector(80);
      random_plan();
      run_stream(1'b1);

      // Reset during beat 7 aborts without a done pulse.
      for (int i = 0; i < N; i++) load_vals[i] = DW'($urandom);
      load_vector(100);
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int j = 1; j <= 7; j++) tick();
      check("abort_beat7_index", input_index, 7);
      check("abort_beat7_valid", neuron_valid, 1);
      #2;
      reset = 1'b0;
      #1;
      check("abort_neuron_valid", neuron_valid, 0);
      check("abort_neuron_in", neuron_in, 0);
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_in_ready", in_ready, 1);
      @(negedge clk);
      reset = 1'b1;
      for (int j = 0; j < 5; j++) begin
         tick();
         check("abort_no_done", done, 0);
         check("abort_in_ready_after", in_ready, 1);
         check("abort_no_valid", neuron_valid, 0);
      end

      // Randomized traffic.
      for (int it = 0; it < 6; it++) begin
         for (int i = 0; i < N; i++) load_vals[i] = DW'($urandom);
         load_vector($urandom_range(100, 40));
         idle_ready($urandom_range(3, 0));
         random_plan();
         run_stream(1'($urandom_range(1)));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/layer_sequencer.md
LAYER_SEQUENCER -- requirements
Module: layer_sequencer

Interface
REQ-001 SHALL have parameters: numInputs, default 16, number of input values per inference; numNeurons, default 4, neurons in the driven layer; dataWidth, default 8, input word width; layerNumber, default 0, this layer's index; counterWidth, default $clog2(numInputs), index width.
REQ-002 SHALL have one clock; reset is asynchronous and active-low.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 inData  in  dataWidth  input value to buffer; inValid  in  1  inData qualifier; inReady  out  1  buffer accepting.
REQ-006 start  in  1  begin streaming the buffered vector.
REQ-007 neuronIn  out  dataWidth  value broadcast to all neurons; neuronValid  out  1  neuronIn qualifier.
REQ-008 inputIndex  out  counterWidth  index of the value on neuronIn.
REQ-009 neuronOutValid  in  numNeurons  per-neuron result strobe.
REQ-010 busy  out  1  streaming or waiting; done  out  1  one-cycle completion pulse.
REQ-011 cfgReq  in  1, cfgIsBias  in  1, cfgNeuron  in  32, cfgData  in  32  configuration write request; cfgAck  out  1  request consumed.
REQ-012 weightWriteEn, biasWriteEn  out  1; weightData, biasData, config_layer_number, config_neuron_number  out  32  forwarded to neurons.

Function
REQ-013 SHALL implement states LOAD, READY, STREAM, WAIT, DONE.
REQ-014 LOAD: inReady=1; each inValid&inReady cycle writes inData to buffer[wrCount], wrCount++; at wrCount==numInputs go READY.
REQ-015 READY: inReady=0; inValid ignored; start=1 goes STREAM and clears rdIdx and the sticky result mask; start in any other state ignored.
REQ-016 STREAM: every cycle neuronValid=1, neuronIn=buffer[rdIdx], inputIndex=rdIdx, rdIdx++; first neuronValid in the cycle after start sampled; exactly numInputs consecutive beats, no gaps; after index numInputs-1 go WAIT.
REQ-017 neuronValid=0 and neuronIn=0 outside STREAM.
REQ-018 Sticky mask ORs in neuronOutValid in STREAM and WAIT; WAIT exits to DONE the cycle after mask is all ones (same cycle if already full on entry).
REQ-019 DONE: done=1 for exactly one cycle, wrCount cleared, next state LOAD; buffer contents not cleared.
REQ-020 busy=1 in STREAM and WAIT only.
REQ-021 Index counters SHALL not wrap past numInputs-1; terminal value triggers the state change.

Reset
REQ-022 reset low SHALL immediately force state LOAD, wrCount=0, rdIdx=0, mask=0, all outputs 0 except inReady=1 after reset deasserts; mid-stream reset aborts with no done pulse.
REQ-023 Buffer storage SHALL not require reset.

Configuration
REQ-024 Macro PRETRAINED_EN: when defined, cfgReq ignored, cfgAck, weightWriteEn, biasWriteEn held 0, all config data outputs 0.
REQ-025 Without PRETRAINED_EN: cfgReq accepted only in LOAD or READY; one cycle later weightWriteEn (cfgIsBias=0) or biasWriteEn (cfgIsBias=1) pulses one cycle with cfgAck, data on weightData/biasData, config_neuron_number=cfgNeuron, config_layer_number=layerNumber.
REQ-026 Without PRETRAINED_EN: cfgReq in STREAM/WAIT/DONE SHALL stall (cfgAck=0) until a legal state; a start in READY coinciding with cfgReq: config accepted, start also taken.

Structure
REQ-027 Package nn_pkg SHALL hold the state enum and default dataWidth/numInputs constants.
REQ-028 Buffer storage with write/read index SHALL be sub-module layer_input_buffer.

Verification
REQ-029 Reset, load 16 values 0x01..0x10, start -> 16 consecutive neuronValid beats, neuronIn 0x01..0x10, inputIndex 0..15.
REQ-030 All neuronOutValid pulse during beat 5, then bits 0..3 at different WAIT cycles -> done one cycle after last bit; busy drops with it.
REQ-031 start asserted in LOAD after 10 values -> ignored, no neuronValid; inValid in READY -> buffer unchanged.
REQ-032 reset low during beat 7 -> neuronValid 0 immediately, no done, inReady=1 after release.
REQ-033 Without PRETRAINED_EN: cfgReq, cfgIsBias=1, cfgData=0x12345678, cfgNeuron=2 in READY -> next cycle biasWriteEn=1, biasData=0x12345678, config_neuron_number=2; same request during STREAM -> cfgAck held 0 until DONE->LOAD.
REQ-034 With PRETRAINED_EN: same request -> no write enables, cfgAck never asserts.
